fifo_pop_ctrl: RTL and testbench

Read-side controller for the synchronous FIFO. Drains words from the FIFO by driving `fifo_rd_en` against `fifo_empty`, absorbs the FIFO's one-cycle read latency, and re-presents each word on a valid/ready stream toward the SPI/RAM datapath. A 2-entry skid buffer lets the downstream side stall without losing in-flight words. The block also flags FIFO underflow.

---
 rtl/fifo_pop_ctrl_pkg.sv | 30 +++
 rtl/fifo_pop_ctrl_skid.sv | 51 +++++
 rtl/fifo_pop_ctrl.sv | 87 ++++++++
 tb/tb_fifo_pop_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pop_ctrl_pkg.sv
// Shared FIFO package: word geometry, read-side controller states
// and skid-buffer sizing.
package fifo_pop_ctrl_pkg;

   localparam int FIFO_WIDTH = 16;
   localparam int FIFO_DEPTH = 16;
   localparam int SKID_DEPTH = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } pop_state_e;

   typedef logic [1:0] occ_t;

   // Room for one more read once the words already owed are counted
   function automatic logic has_credit(
      input occ_t occ,
      input logic inflight,
      input logic xfer
   );
      logic [2:0] owed;
      logic [2:0] room;
      owed = {1'b0, occ} + {2'b00, inflight};
      room = 3'(SKID_DEPTH) + {2'b00, xfer};
      return owed < room;
   endfunction

endpackage

// File: rtl/fifo_pop_ctrl_skid.sv
// Two-entry ordered skid buffer; push and pop may coincide and the
// head register drives the output word directly.
module skid_buf2
   import fifo_pop_ctrl_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic [FIFO_WIDTH-1:0] din,
   output logic [FIFO_WIDTH-1:0] head,
   output occ_t                  occ
);

   logic [FIFO_WIDTH-1:0] tail;
   logic                  do_pop;
   logic                  do_push;

   assign do_pop  = pop && (occ != 2'd0);
   assign do_push = push && ((occ != 2'(SKID_DEPTH)) || do_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
         occ  <= 2'd0;
      end else begin
         unique case (1'b1)
            (do_push && do_pop): begin
               if (occ == 2'd1) begin
                  head <= din;
               end else begin
                  head <= tail;
                  tail <= din;
               end
            end
            (do_push && !do_pop): begin
               if (occ == 2'd0) head <= din;
               else             tail <= din;
               occ <= occ + 2'd1;
            end
            (do_pop && !do_push): begin
               head <= tail;
               occ  <= occ - 2'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/fifo_pop_ctrl.sv
// FIFO read-side controller: issues reads against credit, absorbs the
// one-cycle read latency and re-presents words on a valid/ready stream.
module fifo_pop_ctrl
   import fifo_pop_ctrl_pkg::*;
#(
   parameter int CNT_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic [FIFO_WIDTH-1:0] fifo_data_out,
   input  logic                  fifo_empty,
   input  logic                  fifo_underflow,
   output logic                  fifo_rd_en,
   output logic [FIFO_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  pop_count,
   output logic                  underflow_err
);

   pop_state_e state;
   logic       inflight;
   occ_t       occ;
   logic       xfer;

   assign m_valid = (occ != 2'd0);
   assign xfer    = m_valid && m_ready;
   assign busy    = (state != IDLE);

   // Reads stop during reset so nothing is in flight when it releases
   assign fifo_rd_en = !rst
                    && (state == RUN)
                    && !fifo_empty
                    && has_credit(occ, inflight, xfer);

   skid_buf2 u_skid (
      .clk  (clk),
      .rst  (rst),
      .push (inflight),
      .pop  (xfer),
      .din  (fifo_data_out),
      .head (m_data),
      .occ  (occ)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (enable) state <= RUN;
            end
            RUN: begin
               if (!enable) state <= DRAIN;
            end
            DRAIN: begin
               if (enable)
                  state <= RUN;
               else if (!inflight && (occ == 2'd0))
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inflight      <= 1'b0;
         pop_count     <= '0;
         underflow_err <= 1'b0;
      end else begin
         inflight <= fifo_rd_en;
         if (xfer) pop_count <= pop_count + 1'b1;
         if (fifo_underflow || (fifo_rd_en && fifo_empty))
            underflow_err <= 1'b1;
      end
   end

   a_no_empty_read: assert property (
      @(posedge clk) disable iff (rst) !(fifo_rd_en && fifo_empty)
   );

endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// Randomised bench for fifo_pop_ctrl: a queue-based FIFO and a queue
// model of the stream, checked every cycle, plus literal pins.
module tb_fifo_pop_ctrl;
   import fifo_pop_ctrl_pkg::*;

   localparam int W  = FIFO_WIDTH;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          enable = 1'b0;
   logic [W-1:0]  fifo_data_out = '0;
   logic          fifo_empty = 1'b1;
   logic          fifo_underflow = 1'b0;
   logic          fifo_rd_en;
   logic [W-1:0]  m_data;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic          busy;
   logic [CW-1:0] pop_count;
   logic          underflow_err;

   fifo_pop_ctrl #(.CNT_WIDTH(CW)) dut (
      .clk            (clk),
      .rst            (rst),
      .enable         (enable),
      .fifo_data_out  (fifo_data_out),
      .fifo_empty     (fifo_empty),
      .fifo_underflow (fifo_underflow),
      .fifo_rd_en     (fifo_rd_en),
      .m_data         (m_data),
      .m_valid        (m_valid),
      .m_ready        (m_ready),
      .busy           (busy),
      .pop_count      (pop_count),
      .underflow_err  (underflow_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;
   int cyc = 0;
   int rd_pulses = 0;

   logic [W-1:0]  fq[$];
   logic [W-1:0]  sent[$];
   logic [W-1:0]  log_d[$];
   int            log_c[$];

   // Model: words buffered, one word owed by the FIFO, mode 0/1/2
   logic [W-1:0]  mb[$];
   bit            mi = 0;
   logic [W-1:0]  mi_word = '0;
   int            mst = 0;
   logic [CW-1:0] mcnt = '0;
   bit            merr = 0;

   bit            pstall = 0;
   logic [W-1:0]  pdata = '0;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic clear_log();
      log_d.delete();
      log_c.delete();
      sent.delete();
      rd_pulses = 0;
   endtask

   task automatic step();
      logic [W-1:0] nd;
      bit           rd_now;
      bit           exp_rd;
      bit           exp_v;
      bit           exp_x;
      int           nst;
      fifo_empty = (fq.size() == 0);
      #1;
      exp_v  = (mb.size() > 0);
      exp_x  = exp_v && m_ready;
      exp_rd = (mst == 1) && (fq.size() != 0)
            && (mb.size() + int'(mi) - int'(exp_x) < 2);
      if (!rst) begin
         check("m_valid", 32'(m_valid), 32'(exp_v));
         if (exp_v) check("m_data", 32'(m_data), 32'(mb[0]));
         check("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_rd));
         check("busy", 32'(busy), 32'(mst != 0));
         check("pop_count", 32'(pop_count), 32'(mcnt));
         check("underflow_err", 32'(underflow_err), 32'(merr));
         if (pstall) check("stall_stable", 32'(m_data), 32'(pdata));
      end
      pstall = !rst && (m_valid === 1'b1) && !m_ready;
      pdata  = m_data;
      if (!rst && (m_valid === 1'b1) && m_ready) begin
         log_d.push_back(m_data);
         log_c.push_back(cyc);
      end
      rd_now = (fifo_rd_en === 1'b1);
      if (rd_now) rd_pulses++;
      nd = fifo_data_out;
      if (rd_now && fq.size() > 0) begin
         nd = fq.pop_front();
         sent.push_back(nd);
      end
      if (rst) begin
         mb.delete();
         mi   = 0;
         mst  = 0;
         mcnt = '0;
         merr = 0;
      end else begin
         nst = mst;
         case (mst)
            0:       if (enable) nst = 1;
            1:       if (!enable) nst = 2;
            default: if (enable) nst = 1;
                     else if (!mi && mb.size() == 0) nst = 0;
         endcase
         if (exp_x) begin
            void'(mb.pop_front());
            mcnt++;
         end
         if (mi) mb.push_back(mi_word);
         mi      = exp_rd;
         mi_word = nd;
         if (fifo_underflow) merr = 1;
         mst = nst;
      end
      @(posedge clk);
      #1;
      fifo_data_out = nd;
      cyc++;
      @(negedge clk);
   endtask

   initial begin
      int t0;
      int n;
      @(negedge clk);
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      #1;
      check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_m_data", 32'(m_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_pop_count", 32'(pop_count), 32'd0);
      check("rst_underflow", 32'(underflow_err), 32'd0);

      // Basic drain: four words, one per cycle from enable+3
      clear_log();
      for (int i = 1; i <= 4; i++) fq.push_back(W'(i));
      enable  = 1'b1;
      m_ready = 1'b1;
      t0 = cyc;
      repeat (8) step();
      check("basic_count", 32'(log_d.size()), 32'd4);
      for (int i = 0; i < 4 && i < log_d.size(); i++) begin
         check("basic_data", 32'(log_d[i]), 32'(i + 1));
         check("basic_cycle", 32'(log_c[i] - t0), 32'(i + 3));
      end
      enable = 1'b0;
      repeat (4) step();
      check("basic_idle", 32'(busy), 32'd0);
      check("basic_pop_count", 32'(pop_count), 32'd4);

      // Backpressure with random m_ready
      clear_log();
      for (int i = 0; i < 8; i++) fq.push_back(W'($urandom));
      enable = 1'b1;
      n = 0;
      while (log_d.size() < 8 && n < 100) begin
         m_ready = 1'($urandom_range(0, 1));
         step();
         n++;
      end
      check("bp_count", 32'(log_d.size()), 32'd8);
      for (int i = 0; i < log_d.size() && i < sent.size(); i++)
         check("bp_order", 32'(log_d[i]), 32'(sent[i]));
      enable  = 1'b0;
      m_ready = 1'b1;
      repeat (4) step();

      // Single word: one read, no underflow, stream goes quiet
      clear_log();
      fq.push_back(16'h00a5);
      enable = 1'b1;
      repeat (8) step();
      check("empty_rd_pulses", 32'(rd_pulses), 32'd1);
      check("empty_underflow", 32'(underflow_err), 32'd0);
      check("empty_m_valid", 32'(m_valid), 32'd0);
      check("empty_word", 32'(log_d.size() == 1 ? log_d[0] : 16'h0),
            32'h00a5);
      enable = 1'b0;
      repeat (3) step();

      // Disable mid-stream
      clear_log();
      for (int i = 0; i < 6; i++) fq.push_back(W'(16'h0100 + i));
      enable = 1'b1;
      n = 0;
      while (rd_pulses < 2 && n < 20) begin
         step();
         n++;
      end
      enable = 1'b0;
      repeat (10) step();
      check("dis_remaining",
            32'(fq.size() >= 3 && fq.size() <= 4), 32'd1);
      check("dis_delivered", 32'(log_d.size()), 32'(6 - fq.size()));
      check("dis_idle", 32'(busy), 32'd0);
      fq.delete();

      // Reset with both skid entries full
      clear_log();
      for (int i = 0; i < 4; i++) fq.push_back(W'($urandom));
      m_ready = 1'b0;
      enable  = 1'b1;
      n = 0;
      while (!(mb.size() == 2 && !mi) && n < 20) begin
         step();
         n++;
      end
      check("rst_mid_full", 32'(m_valid && (mb.size() == 2)), 32'd1);
      rst    = 1'b1;
      enable = 1'b0;
      step();
      rst = 1'b0;
      #1;
      check("rst_mid_m_valid", 32'(m_valid), 32'd0);
      check("rst_mid_pop_count", 32'(pop_count), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      fq.delete();
      m_ready = 1'b1;
      repeat (2) step();

      // Sticky underflow
      fifo_underflow = 1'b1;
      step();
      fifo_underflow = 1'b0;
      repeat (5) step();
      check("uf_sticky", 32'(underflow_err), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      check("uf_cleared", 32'(underflow_err), 32'd0);

      // Random soak
      clear_log();
      for (int i = 0; i < 300; i++) begin
         if (fq.size() < 3 && $urandom_range(0, 2) == 0)
            fq.push_back(W'($urandom));
         enable  = ($urandom_range(0, 7) != 0);
         m_ready = 1'($urandom_range(0, 1));
         step();
      end
      enable  = 1'b0;
      m_ready = 1'b1;
      repeat (6) step();
      check("soak_idle", 32'(busy), 32'd0);
      check("soak_all_delivered", 32'(log_d.size()), 32'(sent.size()));

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
